exp_series_engine: RTL and testbench

Parametrised fixed-point exponential unit computing e^x by Taylor series (sum of x^k/k!) with a start/ready handshake. It is the generalised successor of the single-width exp controller/datapath pair: width, fraction split, threshold width and term limit are parameters, and it adds signed-input support, saturation with an overflow flag, a term-count output and a max-term stop. It sits as a coprocessor beside the main datapath, loaded once per operation.

---
 rtl/exp_pkg.sv | 22 ++
 rtl/exp_series_engine_mul.sv | 38 +++
 rtl/exp_series_engine.sv | 169 ++++++++++++++++
 tb/tb_exp_series_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared types and constant generators for the Taylor-series exponential unit.
package exp_pkg;

    // Controller states: one pass through MULX/MULR/ACC produces one series term.
    typedef enum logic [2:0] {
        IDLE,
        MULX,
        MULR,
        ACC,
        DONE
    } state_t;

    // Reciprocal constant floor(2^frac_w / i) in the unit's fixed-point format.
    // Index 0 is never used by the series and returns 0.
    function automatic int recip(input int i, input int frac_w);
        if (i <= 0) begin
            return 0;
        end
        return (1 << frac_w) / i;
    endfunction

endpackage

// File: rtl/exp_series_engine_mul.sv
// Combinational signed fixed-point multiplier: full 2W-bit product, arithmetic
// shift right by FRAC_W (floor rounding), then saturation back to W bits.
module fxp_mul_sat #(
    parameter int W      = 17,
    parameter int FRAC_W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                sat
);

    localparam int PW = 2 * W;
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic                 fits;

    // Multiply, rescale and clamp to the representable W-bit range.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        y       = '0;
        sat     = 1'b0;
        prod    = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        shifted = prod >>> FRAC_W;
        // The value fits when all bits above the W-bit sign position match it.
        fits    = (&shifted[PW-1:W-1]) | ~(|shifted[PW-1:W-1]);
        if (fits) begin
            y = shifted[W-1:0];
        end else begin
            sat = 1'b1;
            y   = shifted[PW-1] ? SMIN : SMAX;
        end
    end

endmodule

// File: rtl/exp_series_engine.sv
// Fixed-point e^x coprocessor: accumulates x^k/k! term by term, each term
// costing three cycles (multiply by x, multiply by 1/i, accumulate), until the
// term drops below the threshold or MAX_TERMS terms have been accumulated.
module exp_series_engine
    import exp_pkg::*;
#(
    parameter int INT_W     = 9,
    parameter int FRAC_W    = 8,
    parameter int THR_W     = 8,
    parameter int MAX_TERMS = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [INT_W+FRAC_W-1:0]            x,
    input  logic [THR_W-1:0]                   thr,
    output logic                               ready,
    output logic                               done,
    output logic [INT_W+FRAC_W-1:0]            result,
    output logic [$clog2(MAX_TERMS+1)-1:0]     n_terms,
    output logic                               ovf
);

    localparam int W      = INT_W + FRAC_W;
    localparam int CNT_W  = $clog2(MAX_TERMS + 1);
    localparam int THR_SH = FRAC_W - THR_W + 1;
    localparam int TBL_N  = 1 << CNT_W;

    localparam logic [W-1:0]     ONE      = {{(INT_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam logic [W-1:0]     SMAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     SMIN     = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TERMS);

    state_t                 state;
    logic signed [W-1:0]    x_reg;
    logic [W-1:0]           thr_ext;
    logic signed [W-1:0]    term;
    logic signed [W-1:0]    acc;
    logic [CNT_W-1:0]       i_cnt;
    logic [CNT_W-1:0]       n_cnt;
    logic                   ovf_run;

    // Reciprocal table 1/i, fully constant; indices past MAX_TERMS are never selected.
    logic signed [W-1:0]    recip_tbl [TBL_N];

    for (genvar g = 0; g < TBL_N; g++) begin : g_recip
        assign recip_tbl[g] = W'(recip(g, FRAC_W));
    end

    // Shared multiplier: x operand in MULX, reciprocal operand in MULR.
    logic signed [W-1:0]    mul_b;
    logic signed [W-1:0]    mul_y;
    logic                   mul_sat;

    assign mul_b = (state == MULR) ? recip_tbl[i_cnt] : x_reg;

    fxp_mul_sat #(
        .W      (W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .a   (term),
        .b   (mul_b),
        .y   (mul_y),
        .sat (mul_sat)
    );

    // Accumulate-stage arithmetic: |term| for the convergence test and a
    // saturating acc + term.
    logic [W:0]             term_ext;
    logic [W:0]             term_abs;
    logic                   below_thr;
    logic [W:0]             sum_ext;
    logic                   acc_ovf;
    logic signed [W-1:0]    acc_sum;
    logic [CNT_W-1:0]       n_next;
    logic                   last_term;

    // Combinational helpers for the ACC state decision.
    always_comb begin
        term_ext  = {term[W-1], term};
        term_abs  = term_ext[W] ? (~term_ext + (W+1)'(1)) : term_ext;
        below_thr = term_abs < {1'b0, thr_ext};
        sum_ext   = {acc[W-1], acc} + {term[W-1], term};
        acc_ovf   = sum_ext[W] ^ sum_ext[W-1];
        acc_sum   = acc_ovf ? (sum_ext[W] ? SMIN : SMAX) : sum_ext[W-1:0];
        n_next    = n_cnt + CNT_ONE;
        last_term = (n_next == CNT_LAST);
    end

    // Controller and datapath registers, including the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= IDLE;
            x_reg   <= '0;
            thr_ext <= '0;
            term    <= '0;
            acc     <= '0;
            i_cnt   <= '0;
            n_cnt   <= '0;
            ovf_run <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            n_terms <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // ready is low during the done cycle, so a start there is ignored.
                    if (ready && start) begin
                        x_reg   <= x;
                        thr_ext <= W'(thr) << THR_SH;
                        term    <= ONE;
                        acc     <= ONE;
                        i_cnt   <= CNT_ONE;
                        n_cnt   <= CNT_ONE;
                        ovf_run <= 1'b0;
                        ready   <= 1'b0;
                        state   <= MULX;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                MULX: begin
                    term    <= mul_y;
                    ovf_run <= ovf_run | mul_sat;
                    state   <= MULR;
                end
                MULR: begin
                    term    <= mul_y;
                    ovf_run <= ovf_run | mul_sat;
                    state   <= ACC;
                end
                ACC: begin
                    if (below_thr) begin
                        result  <= acc;
                        n_terms <= n_cnt;
                        ovf     <= ovf_run;
                        state   <= DONE;
                    end else begin
                        acc     <= acc_sum;
                        n_cnt   <= n_next;
                        i_cnt   <= i_cnt + CNT_ONE;
                        ovf_run <= ovf_run | acc_ovf;
                        if (last_term) begin
                            result  <= acc_sum;
                            n_terms <= n_next;
                            ovf     <= ovf_run | acc_ovf;
                            state   <= DONE;
                        end else begin
                            state <= MULX;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_series_engine.sv
// Directed bench for exp_series_engine with hand-computed Taylor-series results.
module tb_exp_series_engine;

    localparam int INT_W     = 9;
    localparam int FRAC_W    = 8;
    localparam int THR_W     = 8;
    localparam int MAX_TERMS = 15;
    localparam int W         = INT_W + FRAC_W;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              start = 1'b0;
    logic [W-1:0]      x     = '0;
    logic [THR_W-1:0]  thr   = '0;
    logic              ready;
    logic              done;
    logic [W-1:0]      result;
    logic [CNT_W-1:0]  n_terms;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    exp_series_engine #(
        .INT_W     (INT_W),
        .FRAC_W    (FRAC_W),
        .THR_W     (THR_W),
        .MAX_TERMS (MAX_TERMS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .thr     (thr),
        .ready   (ready),
        .done    (done),
        .result  (result),
        .n_terms (n_terms),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [W-1:0]     x;
        logic [THR_W-1:0] thr;
        logic [W-1:0]     res;
        int               n;
        logic             ovf;
        int               done_at;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start (accepted at edge 0) and return the edge number after
    // which done is observed, or -1 if it never comes within the budget.
    task automatic run_op(input logic [W-1:0] xv, input logic [THR_W-1:0] tv,
                          input string name, output int done_at);
        x     = xv;
        thr   = tv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, ".ready_fall"}, 32'(ready), 32'd0);
        done_at = -1;
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (done === 1'b1) begin
                done_at = e;
                break;
            end
        end
    endtask

    vec_t vecs [6];
    int   d;
    int   done_cnt;
    int   first_done;
    int   second_done;
    logic [W-1:0] first_res;
    logic [CNT_W-1:0] first_n;
    logic [W-1:0] second_res;

    initial begin
        vecs[0] = '{"x_one",     17'h00100, 8'h08, 17'h002AA,  4, 1'b0, 13};
        vecs[1] = '{"x_neg_one", 17'h1FF00, 8'h08, 17'h00055,  4, 1'b0, 13};
        vecs[2] = '{"x_zero",    17'h00000, 8'h08, 17'h00100,  1, 1'b0,  4};
        vecs[3] = '{"x_zero_t0", 17'h00000, 8'h00, 17'h00100, 15, 1'b0, 43};
        vecs[4] = '{"x_eight",   17'h00800, 8'h00, 17'h0FFFF, 15, 1'b1, 43};
        vecs[5] = '{"x_half",    17'h00080, 8'h08, 17'h001A0,  3, 1'b0, 10};

        // Reset state.
        rst = 1'b0;
        repeat (3) tick();
        check("rst.ready",   32'(ready),   32'd1);
        check("rst.done",    32'(done),    32'd0);
        check("rst.result",  32'(result),  32'd0);
        check("rst.n_terms", 32'(n_terms), 32'd0);
        check("rst.ovf",     32'(ovf),     32'd0);
        rst = 1'b1;
        tick();

        // Table-driven operations.
        for (int k = 0; k < 6; k++) begin
            run_op(vecs[k].x, vecs[k].thr, vecs[k].name, d);
            check({vecs[k].name, ".done_edge"}, 32'(d),            32'(vecs[k].done_at));
            check({vecs[k].name, ".result"},    32'(result),       32'(vecs[k].res));
            check({vecs[k].name, ".n_terms"},   32'(n_terms),      32'(vecs[k].n));
            check({vecs[k].name, ".ovf"},       32'(ovf),          32'(vecs[k].ovf));
            check({vecs[k].name, ".ready_in_done"}, 32'(ready),    32'd0);
            tick();
            check({vecs[k].name, ".done_pulse"}, 32'(done),        32'd0);
            check({vecs[k].name, ".ready_rise"}, 32'(ready),       32'd1);
            check({vecs[k].name, ".result_hold"}, 32'(result),     32'(vecs[k].res));
        end

        // Reset mid-operation: leave saturated results behind first so the clear is visible.
        run_op(17'h00800, 8'h00, "pre_rst", d);
        tick();
        x     = 17'h00100;
        thr   = 8'h08;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst.ready",   32'(ready),   32'd1);
        check("midrst.done",    32'(done),    32'd0);
        check("midrst.result",  32'(result),  32'd0);
        check("midrst.n_terms", 32'(n_terms), 32'd0);
        check("midrst.ovf",     32'(ovf),     32'd0);
        done_cnt = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        check("midrst.no_done", 32'(done_cnt), 32'd0);
        run_op(17'h00100, 8'h08, "after_rst", d);
        check("after_rst.done_edge", 32'(d),      32'd13);
        check("after_rst.result",    32'(result), 32'h002AA);
        tick();

        // Start held high, inputs changed mid-operation, start present in the done cycle.
        x     = 17'h00100;
        thr   = 8'h08;
        start = 1'b1;
        tick();
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        first_res   = '0;
        first_n     = '0;
        second_res  = '0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 1) begin
                x   = 17'h1FF00;
                thr = 8'h00;
            end
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = e;
                    first_res  = result;
                    first_n    = n_terms;
                end else if (second_done < 0) begin
                    second_done = e;
                    second_res  = result;
                end
            end
            if (e == 14) begin
                check("held.ready_after_done", 32'(ready), 32'd1);
                x   = 17'h00000;
                thr = 8'h08;
            end
            if (e == 15) begin
                check("held.accept_next", 32'(ready), 32'd0);
                start = 1'b0;
            end
        end
        check("held.first_done",  32'(first_done),  32'd13);
        check("held.first_res",   32'(first_res),   32'h002AA);
        check("held.first_n",     32'(first_n),     32'd4);
        check("held.done_count",  32'(done_cnt),    32'd2);
        check("held.second_done", 32'(second_done), 32'd19);
        check("held.second_res",  32'(second_res),  32'h00100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
